// File: rtl/ser_pkg.sv
// -----------------------------------------------------------------------------
// ser_pkg
//   Shared definitions for the block serializer that feeds the
//   G(x) = x^58 + x^39 + 1 serial scrambler.
//   - Block geometry: 2-bit sync header followed by a 64-bit payload.
//   - Sync header codes and the idle block inserted on starvation.
//   - Serializer FSM state type and the block struct.
//   - Helper that flattens a block into its transmit order (bit 0 first).
// -----------------------------------------------------------------------------
package ser_pkg;

   localparam int HDR_W = 2;
   localparam int PAY_W = 64;
   localparam int BLK_W = HDR_W + PAY_W;
   localparam int CNT_W = $clog2(PAY_W);

   localparam logic [HDR_W-1:0] SYNC_DATA = 2'b01;
   localparam logic [HDR_W-1:0] SYNC_CTRL = 2'b10;
   localparam logic [HDR_W-1:0] IDLE_HDR  = SYNC_CTRL;
   localparam logic [PAY_W-1:0] IDLE_PAY  = 64'h1E;

   typedef enum logic [1:0] {
      S_WAIT,
      S_HDR,
      S_PAY
   } ser_state_t;

   typedef struct packed {
      logic [HDR_W-1:0] hdr;
      logic [PAY_W-1:0] pay;
   } blk_t;

   localparam blk_t IDLE_BLK = '{hdr: IDLE_HDR, pay: IDLE_PAY};

   // Transmit order: header bit 0 first, then header bits, then payload
   // bit 0 upward. Bit 0 of the result is the first bit on the line.
   function automatic logic [BLK_W-1:0] blk_to_seq(input blk_t b);
      return {b.pay, b.hdr};
   endfunction

endpackage

// File: rtl/block_buffer.sv
// -----------------------------------------------------------------------------
// block_buffer
//   One-entry valid/ready holding register between the upstream block source
//   and the serializer. Accepts a block when empty, releases it on pop.
//   There is no pass-through: ready depends only on the stored valid, so a
//   block can never be accepted and popped in the same cycle.
//
// Ports
//   CLK          clock, all logic on posedge
//   reset        synchronous active-high; empties the buffer
//   in_valid     upstream block valid
//   in_ready     buffer can accept (low while reset is high)
//   in_header    upstream sync header
//   in_payload   upstream payload
//   pop          serializer takes the stored block this cycle
//   buf_valid    a block is stored
//   buf_header   stored sync header
//   buf_payload  stored payload
// -----------------------------------------------------------------------------
module block_buffer
   import ser_pkg::*;
(
   input  logic             CLK,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [HDR_W-1:0] in_header,
   input  logic [PAY_W-1:0] in_payload,
   input  logic             pop,
   output logic             buf_valid,
   output logic [HDR_W-1:0] buf_header,
   output logic [PAY_W-1:0] buf_payload
);

   logic valid_q;
   blk_t data_q;

   assign in_ready = ~reset & ~valid_q;

   // NOTE: sequential state is written with non-blocking assignments so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge CLK) begin
      if (reset) begin
         valid_q <= 1'b0;
      end else if (pop) begin
         valid_q <= 1'b0;
      end else if (in_valid && in_ready) begin
         valid_q <= 1'b1;
      end
   end

   // NOTE: the data register has no reset; it is only ever read while valid_q
   // is set, so clearing it would add reset fan-out for no functional gain.
   always_ff @(posedge CLK) begin
      if (in_valid && in_ready) begin
         data_q <= '{hdr: in_header, pay: in_payload};
      end
   end

   assign buf_valid   = valid_q;
   assign buf_header  = data_q.hdr;
   assign buf_payload = data_q.pay;

endmodule

// File: rtl/block_serializer.sv
// -----------------------------------------------------------------------------
// block_serializer
//   Serializes 66-bit blocks (2-bit sync header + 64-bit payload) one bit per
//   enabled cycle for the x^58+x^39+1 serial scrambler. Header bits are
//   flagged so the downstream mux bypasses the scrambler; payload bits advance
//   it. When no block is buffered at a block boundary an idle block
//   (header 2'b10, payload 64'h1E) is sent instead and underrun pulses.
//
//   The FSM state describes the bit currently presented on Bit_Out. That bit
//   is consumed by the scrambler on the next enabled edge, and the same edge
//   presents the following bit, so blocks follow each other without gaps.
//
// Ports
//   CLK          clock, all logic on posedge
//   reset        synchronous active-high; discards any block in flight
//   enable       line bit strobe; one serial bit per enabled cycle
//   in_valid     upstream block valid
//   in_ready     block buffer can accept
//   in_header    sync header, bit 0 transmitted first
//   in_payload   payload, bit 0 transmitted first
//   Bit_Out      serial bit to scrambler Bit_In (registered)
//   scr_enable   scrambler enable = enable & active & ~hdr_flag
//   hdr_flag     Bit_Out is a header bit
//   block_start  Bit_Out is header bit 0 of a block (gated by enable)
//   underrun     Bit_Out starts an inserted idle block (gated by enable)
// -----------------------------------------------------------------------------
module block_serializer
   import ser_pkg::*;
(
   input  logic             CLK,
   input  logic             reset,
   input  logic             enable,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [HDR_W-1:0] in_header,
   input  logic [PAY_W-1:0] in_payload,
   output logic             Bit_Out,
   output logic             scr_enable,
   output logic             hdr_flag,
   output logic             block_start,
   output logic             underrun
);

   logic             buf_valid;
   logic [HDR_W-1:0] buf_header;
   logic [PAY_W-1:0] buf_payload;
   logic             pop;

   ser_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic [BLK_W-1:0] sreg_q,  sreg_d;
   logic             bit_q,   bit_d;
   logic             hdr_q,   hdr_d;
   logic             start_q, start_d;
   logic             idle_q,  idle_d;

   logic             load;
   blk_t             next_blk;
   logic [BLK_W-1:0] next_seq;
   logic             active;

   block_buffer u_buf (
      .CLK         (CLK),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_header   (in_header),
      .in_payload  (in_payload),
      .pop         (pop),
      .buf_valid   (buf_valid),
      .buf_header  (buf_header),
      .buf_payload (buf_payload)
   );

   // Block presented at the next boundary: the buffered one if present,
   // otherwise the idle block.
   always_comb begin
      if (buf_valid) begin
         next_blk = '{hdr: buf_header, pay: buf_payload};
      end else begin
         next_blk = IDLE_BLK;
      end
   end

   assign next_seq = blk_to_seq(next_blk);
   assign pop      = load & buf_valid;

   // NOTE: every signal written here gets a default first, so no path leaves
   // a value unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sreg_d  = sreg_q;
      bit_d   = bit_q;
      hdr_d   = hdr_q;
      start_d = start_q;
      idle_d  = idle_q;
      load    = 1'b0;

      if (enable) begin
         // Default enabled-cycle action: present the next bit of the block.
         start_d = 1'b0;
         idle_d  = 1'b0;
         bit_d   = sreg_q[0];
         sreg_d  = sreg_q >> 1;
         cnt_d   = cnt_q + CNT_W'(1);

         unique case (state_q)
            S_WAIT: begin
               load = 1'b1;
            end
            S_HDR: begin
               if (cnt_q == CNT_W'(HDR_W - 1)) begin
                  state_d = S_PAY;
                  cnt_d   = '0;
                  hdr_d   = 1'b0;
               end
            end
            S_PAY: begin
               // Last payload bit is being consumed: the next block's header
               // bit 0 follows immediately.
               if (cnt_q == CNT_W'(PAY_W - 1)) begin
                  load = 1'b1;
               end
            end
            default: begin
               state_d = S_WAIT;
               cnt_d   = '0;
               hdr_d   = 1'b0;
            end
         endcase

         if (load) begin
            bit_d   = next_seq[0];
            sreg_d  = next_seq >> 1;
            state_d = S_HDR;
            cnt_d   = '0;
            hdr_d   = 1'b1;
            start_d = 1'b1;
            idle_d  = ~buf_valid;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q <= S_WAIT;
         cnt_q   <= '0;
         bit_q   <= 1'b0;
         hdr_q   <= 1'b0;
         start_q <= 1'b0;
         idle_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         hdr_q   <= hdr_d;
         start_q <= start_d;
         idle_q  <= idle_d;
      end
   end

   // The shift register is always reloaded before it is read after reset.
   always_ff @(posedge CLK) begin
      sreg_q <= sreg_d;
   end

   assign active      = (state_q != S_WAIT);
   assign Bit_Out     = bit_q;
   assign hdr_flag    = hdr_q;
   assign scr_enable  = enable & active & ~hdr_q;
   assign block_start = enable & start_q;
   assign underrun    = enable & idle_q;

endmodule

// File: tb/tb_block_serializer.sv
// -----------------------------------------------------------------------------
// tb_block_serializer
//   Self-checking bench for block_serializer. A reference model counts enabled
//   cycles since reset: every 66 enabled cycles a block boundary occurs, at
//   which the oldest accepted block (or the idle block) becomes current, and
//   the bit on the line is simply bit (n % 66) of that block in transmit order.
// -----------------------------------------------------------------------------
module tb_block_serializer;

   localparam int               BLK_BITS   = 66;
   localparam logic [1:0]       T_IDLE_HDR = 2'b10;
   localparam logic [63:0]      T_IDLE_PAY = 64'h1E;
   localparam logic [63:0]      T2_PAY     = 64'h0123456789ABCDEF;

   logic        CLK = 1'b0;
   logic        reset;
   logic        enable;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_header;
   logic [63:0] in_payload;
   logic        Bit_Out;
   logic        scr_enable;
   logic        hdr_flag;
   logic        block_start;
   logic        underrun;

   block_serializer dut (
      .CLK         (CLK),
      .reset       (reset),
      .enable      (enable),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_header   (in_header),
      .in_payload  (in_payload),
      .Bit_Out     (Bit_Out),
      .scr_enable  (scr_enable),
      .hdr_flag    (hdr_flag),
      .block_start (block_start),
      .underrun    (underrun)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   int          nen = 0;           // enabled edges since reset
   logic [65:0] mq[$];             // accepted, not yet transmitted blocks
   logic [65:0] cur_seq = '0;      // block currently on the line
   bit          cur_idle = 1'b0;

   // Upstream driver state
   bit          pend_valid = 1'b0;
   logic [1:0]  pend_hdr   = '0;
   logic [63:0] pend_pay   = '0;
   int          vld_rate   = 0;
   int          blk_budget = 0;

   // Observation tallies
   int obs_un, obs_bs, obs_scr, obs_rdy, obs_scr_dis;
   bit cap[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic clear_tallies();
      obs_un = 0; obs_bs = 0; obs_scr = 0; obs_rdy = 0; obs_scr_dis = 0;
      cap.delete();
   endtask

   // One clock cycle: drive at the negedge, check 1 ns later, update the model
   // at the posedge, return at the following negedge.
   task automatic step(input bit rst, input bit en);
      int p;
      bit acc;
      if (!pend_valid && blk_budget > 0 && $urandom_range(99) < vld_rate) begin
         pend_valid = 1'b1;
         pend_hdr   = 2'($urandom);
         pend_pay   = {$urandom, $urandom};
         blk_budget--;
      end
      reset      = rst;
      enable     = en;
      in_valid   = pend_valid;
      in_header  = pend_hdr;
      in_payload = pend_pay;
      #1;
      check("in_ready", in_ready, (!rst && mq.size() == 0));
      if (nen == 0) begin
         check("idle_bit", Bit_Out, 1'b0);
         check("idle_hdr_flag", hdr_flag, 1'b0);
         check("idle_scr_enable", scr_enable, 1'b0);
         check("idle_block_start", block_start, 1'b0);
         check("idle_underrun", underrun, 1'b0);
      end else begin
         p = (nen - 1) % BLK_BITS;
         check("bit_out", Bit_Out, cur_seq[p]);
         check("hdr_flag", hdr_flag, (p < 2));
         check("scr_enable", scr_enable, (en && p >= 2));
         check("block_start", block_start, (en && p == 0));
         check("underrun", underrun, (en && p == 0 && cur_idle));
      end
      if (underrun === 1'b1)    obs_un++;
      if (block_start === 1'b1) obs_bs++;
      if (in_ready === 1'b1)    obs_rdy++;
      if (scr_enable === 1'b1) begin
         obs_scr++;
         if (!en) obs_scr_dis++;
         if (en) cap.push_back(Bit_Out);
      end
      acc = !rst && pend_valid && mq.size() == 0;
      @(posedge CLK);
      if (rst) begin
         nen = 0;
         mq.delete();
      end else begin
         if (en) begin
            if (nen % BLK_BITS == 0) begin
               if (mq.size() > 0) begin
                  cur_seq  = mq.pop_front();
                  cur_idle = 1'b0;
               end else begin
                  cur_seq  = {T_IDLE_PAY, T_IDLE_HDR};
                  cur_idle = 1'b1;
               end
            end
            nen++;
         end
         if (acc) begin
            mq.push_back({pend_pay, pend_hdr});
            pend_valid = 1'b0;
         end
      end
      @(negedge CLK);
   endtask

   task automatic do_reset(input int cycles);
      pend_valid = 1'b0;
      blk_budget = 0;
      for (int i = 0; i < cycles; i++) step(1'b1, 1'b0);
   endtask

   // Scramble with x^58+x^39+1 and descramble again; both start from zero.
   function automatic logic [63:0] scr_loop(input logic [63:0] d);
      logic [57:0] s;
      logic [57:0] r;
      logic [63:0] o;
      logic        sb;
      s = '0; r = '0; o = '0;
      for (int i = 0; i < 64; i++) begin
         sb   = d[i] ^ s[38] ^ s[57];
         s    = {s[56:0], sb};
         o[i] = sb ^ r[38] ^ r[57];
         r    = {r[56:0], sb};
      end
      return o;
   endfunction

   function automatic logic [63:0] cap_word();
      logic [63:0] w;
      w = '0;
      for (int i = 0; i < 64 && i < cap.size(); i++) w[i] = cap[i];
      return w;
   endfunction

   task automatic load_t2_block();
      pend_valid = 1'b1;
      pend_hdr   = 2'b01;
      pend_pay   = T2_PAY;
      vld_rate   = 0;
      blk_budget = 0;
      step(1'b0, 1'b0);
   endtask

   initial begin
      int guard;
      int en_cnt;
      reset = 1'b1; enable = 1'b0; in_valid = 1'b0;
      in_header = '0; in_payload = '0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);

      // 1: reset held 3 cycles, then ready on the first cycle after
      do_reset(3);
      step(1'b0, 1'b0);

      // 2: single data block, enable always high
      do_reset(1);
      load_t2_block();
      clear_tallies();
      for (int i = 0; i < 67; i++) step(1'b0, 1'b1);
      check("t2_scr_cnt", obs_scr, 64);
      check("t2_bs_cnt", obs_bs, 1);
      check("t2_cap_len", cap.size(), 64);
      check("t2_descrambled", scr_loop(cap_word()), T2_PAY);

      // 3: starvation after two blocks
      do_reset(1);
      vld_rate = 100; blk_budget = 2;
      step(1'b0, 1'b0);
      clear_tallies();
      for (int i = 0; i < 1 + 5 * BLK_BITS; i++) step(1'b0, 1'b1);
      check("t3_underrun_cnt", obs_un, 3);

      // 4: back-to-back, upstream always valid
      do_reset(1);
      vld_rate = 100; blk_budget = 11;
      step(1'b0, 1'b0);
      clear_tallies();
      step(1'b0, 1'b1);
      for (int i = 0; i < 10 * BLK_BITS; i++) step(1'b0, 1'b1);
      check("t4_underrun_cnt", obs_un, 0);
      check("t4_ready_cnt", obs_rdy, 10);

      // 5: enable toggled 1-0-1, same block as test 2
      do_reset(1);
      load_t2_block();
      clear_tallies();
      en_cnt = 0;
      for (int i = 0; en_cnt < 67; i++) begin
         step(1'b0, (i % 2) == 0);
         if ((i % 2) == 0) en_cnt++;
      end
      check("t5_scr_cnt", obs_scr, 64);
      check("t5_scr_when_disabled", obs_scr_dis, 0);
      check("t5_bs_cnt", obs_bs, 1);
      check("t5_descrambled", scr_loop(cap_word()), T2_PAY);

      // 6: reset at payload bit 30 with buffer full
      do_reset(1);
      vld_rate = 100; blk_budget = 100;
      guard = 0;
      while (!(nen > 0 && (nen - 1) % BLK_BITS == 32 && mq.size() == 1) && guard < 500) begin
         step(1'b0, 1'b1);
         guard++;
      end
      check("t6_reached_bit30", (guard < 500), 1'b1);
      step(1'b1, 1'b1);
      pend_valid = 1'b0; blk_budget = 0;
      clear_tallies();
      step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      check("t6_underrun_cnt", obs_un, 1);
      check("t6_bs_cnt", obs_bs, 1);

      // 7: random enable, valid and occasional reset
      do_reset(1);
      vld_rate = 50; blk_budget = 1000;
      for (int i = 0; i < 2000; i++) begin
         step(($urandom_range(99) < 1), ($urandom_range(99) < 70));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
